lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store controller sitting directly upstream of the data memory.
- Accepts one memory request at a time from the pipeline MEM stage and handles byte, halfword and word access.
- Loads: sign/zero extension. Sub-word stores: read-modify-write, because the data memory only performs full 32-bit writes at the presented address.
- Drives the data memory's word-aligned address/we/wdata port and consumes its combinational read data.

Parameters:
- MISALIGN_TRAP, 1: 1 = misaligned or reserved-size request returns resp_err with no memory access; 0 = low address bits forced to natural alignment and the access proceeds.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved size; valid with resp_valid.
- mem_we  out  1  data memory write enable.
- mem_addr  out  32  word-aligned address, low 2 bits always 0.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational word read at mem_addr.

Behaviour:
- Reset: rst low asynchronously forces IDLE, clears all request/merge registers, and drives all outputs low:
  - mem_we=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0.
  - req_ready=0 only while rst is low; it is 1 in IDLE after release.
- States: IDLE, RD, WR, DONE.
- Handshake:
  - req_ready=1 only in IDLE.
  - Accept occurs on a clock edge with req_valid&&req_ready; all req_* fields are latched at that edge.
  - req_* are ignored outside IDLE.
- Alignment:
  - byte is always aligned; half requires addr[0]=0; word requires addr[1:0]=0.
  - size 11 is always an error.
- Transitions from IDLE on accept:
  - Error with MISALIGN_TRAP=1 -> DONE, resp_err=1.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD.
- RD:
  - Drives mem_addr={addr[31:2],2'b00}, mem_we=0.
  - Load: the selected lane is extracted from mem_rdata and extended into resp_rdata at the edge, then -> DONE.
  - Sub-word store: mem_rdata is captured into the merge register, then -> WR.
- Lane select:
  - Byte lane = addr[1:0]: bits [8*k+7:8*k].
  - Half lane = addr[1]: bits [15:0] or [31:16].
- WR:
  - mem_we=1 for exactly one cycle; mem_addr is the aligned word address.
  - mem_wdata = req_wdata for a word store.
  - Otherwise mem_wdata = the merge word with only the addressed byte/half replaced by req_wdata[7:0] or [15:0].
  - Then -> DONE.
- DONE:
  - resp_valid=1 for one cycle; resp_rdata and resp_err are held valid.
  - Next state is IDLE; the next accept is possible one cycle after DONE.
- Latency, accept edge T to the resp_valid cycle:
  - error: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Outside RD/WR: mem_addr=0, mem_wdata=0, mem_we=0.
- resp_rdata/resp_err hold their last values until the next DONE. They are cleared to 0 on DONE of a store.
- Reset asserted during RD or WR:
  - mem_we drops immediately (it is decoded from state) and no partial write is completed.
  - The request is dropped and resp_valid is not produced.

Test Plan:
- Reset then idle: rst low mid-WR of a sub-word store -> mem_we falls within the same cycle. After release: req_ready=1, resp_valid=0, no write seen at memory.
- Word store then load:
  - store 0xDEADBEEF @0x10 -> mem_we=1 one cycle with mem_addr=0x10, resp_valid at T+2.
  - word load @0x10 -> resp_rdata=0xDEADBEEF at T+2.
- Byte load extension, memory word 0x80FF7F01 @0x20:
  - signed byte @0x23 -> 0xFFFFFF80.
  - unsigned byte @0x23 -> 0x00000080.
  - signed half @0x20 -> 0x00007F01.
  - signed half @0x22 -> 0xFFFF80FF.
- Sub-word store RMW, memory word 0x11223344 @0x30:
  - byte store 0xAA @0x31 -> RD then WR with mem_wdata=0x1122AA44, resp_valid at T+3.
  - half store 0xBEEF @0x32 -> 0xBEEF3344.
- Misalign, MISALIGN_TRAP=1: word load @0x41 and half store @0x43 -> mem_we never asserted, resp_valid at T+1, resp_err=1, resp_rdata=0.
- Back-to-back: req_valid held high with 3 queued requests -> each accepted only when req_ready=1, and each resp_valid pulse is one cycle wide.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response and data-memory signal bundle for lsu_ctrl
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: sub-word extension on loads, read-modify-write for sub-word stores
module lsu_ctrl #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misalign;
  logic        w_err_req;
  logic [1:0]  w_size_eff;
  logic [31:0] w_addr_eff;
  logic [31:0] w_addr_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  assign bus.req_ready  = (r_state == S_IDLE) && i_rst_n;
  assign bus.resp_valid = (r_state == S_DONE);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_misalign  = (bus.req_size == 2'b11) ||
                       (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_size == 2'b10 && (bus.req_addr[1:0] != 2'b00));
  assign w_err_req   = MISALIGN_TRAP && w_misalign;
  assign w_addr_word = {r_addr[31:2], 2'b00};

  // Without trapping, reserved size degrades to a word and low address bits are masked.
  always_comb begin
    w_size_eff = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
    case (w_size_eff)
      2'b00:   w_addr_eff = bus.req_addr;
      2'b01:   w_addr_eff = {bus.req_addr[31:1], 1'b0};
      default: w_addr_eff = {bus.req_addr[31:2], 2'b00};
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = bus.mem_rdata[7:0];
      2'b01:   w_byte = bus.mem_rdata[15:8];
      2'b10:   w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load_ext = bus.mem_rdata;
    endcase
    w_merged = r_merge;
    case (r_size)
      2'b00: begin
        case (r_addr[1:0])
          2'b00:   w_merged[7:0]   = r_wdata[7:0];
          2'b01:   w_merged[15:8]  = r_wdata[7:0];
          2'b10:   w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
        else           w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // mem_we is decoded from state so a reset mid-write kills it immediately.
  always_comb begin
    w_next        = r_state;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err_req)                 w_next = S_DONE;
          else if (!bus.req_we)          w_next = S_RD;
          else if (w_size_eff == 2'b10)  w_next = S_WR;
          else                           w_next = S_RD;
        end
      end
      S_RD: begin
        bus.mem_addr = w_addr_word;
        w_next       = r_we ? S_WR : S_DONE;
      end
      S_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_addr_word;
        bus.mem_wdata = w_merged;
        w_next        = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_merge <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_size  <= w_size_eff;
            r_uns   <= bus.req_unsigned;
            r_addr  <= w_addr_eff;
            r_wdata <= bus.req_wdata;
            if (w_err_req) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
            end
          end
        end
        S_RD: begin
          if (r_we) begin
            r_merge <= bus.mem_rdata;
          end else begin
            r_rdata <= w_load_ext;
            r_err   <= 1'b0;
          end
        end
        S_WR: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized and directed bench for lsu_ctrl against a byte-array memory model
module tb_lsu_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MISALIGN_TRAP(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [31:0] sram [0:63];
  logic [7:0]  refb [0:255];
  logic        load_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int w = 0; w < 64; w++)
        sram[w] <= {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    end else if (bus.mem_we) begin
      sram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = sram[bus.mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    int b;
    b = {24'h0, a[7:2], 2'b00};
    return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    int b;
    b = {24'h0, a[7:2], 2'b00};
    for (int i = 0; i < 4; i++) refb[b+i] = v[8*i +: 8];
  endtask

  // Caller must be at a negedge; returns at the negedge after the response cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit keep,
                        output logic [31:0] got_rdata, output logic [31:0] got_wdata);
    logic        err;
    int          n, idx, k, wcnt, wt, exp_lat;
    logic [31:0] val, exp_rdata, exp_wdata, waddr, wd;
    bit          busy_rdy;
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    n = 1 << size;
    exp_rdata = 32'h0;
    if (err) begin
      exp_lat = 1;
    end else if (!we) begin
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
        idx = {24'h0, addr[7:0]} + i;
        val = val | ({24'h0, refb[idx]} << (8*i));
      end
      if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      exp_rdata = val;
      exp_lat = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        idx = {24'h0, addr[7:0]} + i;
        refb[idx] = wdata[8*i +: 8];
      end
      exp_lat = (n == 4) ? 2 : 3;
    end
    exp_wdata = ref_word(addr[7:0]);

    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    wt = 0;
    while (!bus.req_ready && wt < 8) begin
      @(negedge clk);
      wt++;
    end
    check("req_ready_before_accept", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    k = 0; wcnt = 0; busy_rdy = 0; waddr = 32'h0; wd = 32'h0;
    while (k < 8) begin
      @(negedge clk);
      k++;
      if (bus.req_ready) busy_rdy = 1;
      if (bus.mem_we) begin
        wcnt++;
        waddr = bus.mem_addr;
        wd    = bus.mem_wdata;
      end
      if (bus.resp_valid) break;
      // Fields must be ignored while busy.
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_valid    = keep ? 1'b1 : 1'($urandom);
    end
    check("latency", 32'(k), 32'(exp_lat));
    check("resp_rdata", bus.resp_rdata, exp_rdata);
    check("resp_err", {31'h0, bus.resp_err}, {31'h0, err});
    check("ready_while_busy", {31'h0, busy_rdy}, 32'h0);
    check("write_count", 32'(wcnt), (we && !err) ? 32'h1 : 32'h0);
    check("mem_addr_in_done", bus.mem_addr, 32'h0);
    if (we && !err) begin
      check("write_addr", waddr, {addr[31:2], 2'b00});
      check("write_data", wd, exp_wdata);
    end
    got_rdata = bus.resp_rdata;
    got_wdata = wd;
    bus.req_valid = keep;
    @(negedge clk);
    check("resp_pulse_width", {31'h0, bus.resp_valid}, 32'h0);
    check("ready_after_done", {31'h0, bus.req_ready}, 32'h1);
  endtask

  logic [31:0] r, w;
  logic [1:0]  sz;
  logic [31:0] a;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    load_mem = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) set_word(8'(4*i), $urandom);
    set_word(8'h20, 32'h80FF7F01);
    set_word(8'h30, 32'h11223344);
    set_word(8'h34, 32'h11223344);
    #1;
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, r, w);
    check("sw_wdata", w, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, w);
    check("lw_rdata", r, 32'hDEADBEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, r, w);
    check("lb_signed", r, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0, r, w);
    check("lb_unsigned", r, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, r, w);
    check("lh_low", r, 32'h00007F01);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, r, w);
    check("lh_high", r, 32'hFFFF80FF);
    do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA, 1'b0, r, w);
    check("sb_merge", w, 32'h1122AA44);
    do_req(1'b1, 2'b01, 1'b0, 32'h36, 32'h0000BEEF, 1'b0, r, w);
    check("sh_merge", w, 32'hBEEF3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 1'b0, r, w);
    check("misalign_lw_rdata", r, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h43, 32'h1234, 1'b0, r, w);
    do_req(1'b1, 2'b11, 1'b0, 32'h44, 32'h1234, 1'b0, r, w);

    do_req(1'b1, 2'b00, 1'b0, 32'h61, 32'h77, 1'b1, r, w);
    do_req(1'b0, 2'b01, 1'b0, 32'h60, 32'h0, 1'b1, r, w);
    do_req(1'b1, 2'b10, 1'b0, 32'h64, 32'hCAFEF00D, 1'b0, r, w);

    // Reset during the write cycle of a byte store must abort it cleanly.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h51; bus.req_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_case_we_in_wr", {31'h0, bus.mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_case_we_drop", {31'h0, bus.mem_we}, 32'h0);
    check("rst_case_addr", bus.mem_addr, 32'h0);
    check("rst_case_ready", {31'h0, bus.req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    end
    check("post_rst_no_write", sram[20], ref_word(8'h50));

    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom);
      a  = {24'h0, 8'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, (t < 149) ? 1'($urandom) : 1'b0, r, w);
    end

    for (int i = 0; i < 64; i++)
      check("final_mem", sram[i], ref_word(8'(4*i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
